// File: rtl/br_param.sv
// Clearable register bank: two combinational read ports, one write port,
// DEPTH-cycle clear after reset. Optional write-first bypass: BR_BYPASS_EN.

module br_param_rd #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int ZERO_REG = 1
) (
   input  logic              busy,
   input  logic              byp,
   input  logic [ADDR_W-1:0] ra,
   input  logic [DATA_W-1:0] ent,
   input  logic [DATA_W-1:0] wd,
   output logic [DATA_W-1:0] rd
);
   always_comb begin
      rd = byp ? wd : ent;
      if (busy || (ZERO_REG != 0 && ra == '0)) rd = '0;
   end
endmodule

module br_param #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int ZERO_REG = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] RR1,
   input  logic [ADDR_W-1:0] RR2,
   input  logic [ADDR_W-1:0] WriteReg,
   input  logic [DATA_W-1:0] WriteData,
   input  logic              RegWrite,
   output logic [DATA_W-1:0] RD1,
   output logic [DATA_W-1:0] RD2,
   output logic              Busy
);
   localparam int DEPTH   = 1 << ADDR_W;
   localparam int NPORTS  = 2;

   typedef enum logic {CLEAR = 1'b0, READY = 1'b1} state_t;

   state_t              state, state_nxt;
   logic [ADDR_W-1:0]   cnt, cnt_nxt;
   logic [DATA_W-1:0]   mem [DEPTH];
   logic                wr_en;

   logic [NPORTS-1:0][ADDR_W-1:0] ra;
   logic [NPORTS-1:0][DATA_W-1:0] rd;
   logic [NPORTS-1:0]             byp;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= CLEAR;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // cnt wraps to 0 on the same edge that leaves CLEAR
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      if (state == CLEAR) begin
         cnt_nxt = cnt + 1'b1;
         if (&cnt) state_nxt = READY;
      end
   end

   always_comb begin
      Busy = (state == CLEAR);
   end

   assign wr_en = (state == READY) && RegWrite &&
                  !(ZERO_REG != 0 && WriteReg == '0);

   // Contents are held while rst_n is low; clearing only runs after release
   always_ff @(posedge clk) begin
      if (rst_n) begin
         if (state == CLEAR)  mem[cnt]      <= '0;
         else if (wr_en)      mem[WriteReg] <= WriteData;
      end
   end

   assign ra = {RR2, RR1};

   for (genvar p = 0; p < NPORTS; p++) begin : g_rd
`ifdef BR_BYPASS_EN
      assign byp[p] = wr_en && (ra[p] == WriteReg);
`else
      assign byp[p] = 1'b0;
`endif
      br_param_rd #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG)) u_rd (
         .busy (Busy),
         .byp  (byp[p]),
         .ra   (ra[p]),
         .ent  (mem[ra[p]]),
         .wd   (WriteData),
         .rd   (rd[p])
      );
   end

   assign RD1 = rd[0];
   assign RD2 = rd[1];
endmodule

// File: tb/tb_br_param.sv
// Directed bench for br_param (default parameters); expectations follow
// the BR_BYPASS_EN build setting.

module tb_br_param;
   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [ADDR_W-1:0] RR1, RR2, WriteReg;
   logic [DATA_W-1:0] WriteData;
   logic              RegWrite;
   logic [DATA_W-1:0] RD1, RD2;
   logic              Busy;

   int n_chk  = 0;
   int n_fail = 0;
   int busy_n;

`ifdef BR_BYPASS_EN
   localparam logic [31:0] COLL17 = 32'd47;
`else
   localparam logic [31:0] COLL17 = 32'd0;
`endif

   br_param dut (
      .clk(clk), .rst_n(rst_n), .RR1(RR1), .RR2(RR2), .WriteReg(WriteReg),
      .WriteData(WriteData), .RegWrite(RegWrite), .RD1(RD1), .RD2(RD2), .Busy(Busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // one reset edge, then count post-edge samples with Busy high (bounded)
   task automatic reset_and_count(output int n);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      n = 0;
      while (Busy === 1'b1 && n < 100) begin
         n++;
         tick();
      end
   endtask

   task automatic wr(input logic [4:0] a, input logic [31:0] d);
      RegWrite = 1'b1; WriteReg = a; WriteData = d;
      tick();
      RegWrite = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; RegWrite = 1'b0; WriteReg = '0; WriteData = '0;
      RR1 = 5'd5; RR2 = 5'd31;

      // reset state
      tick();
      chk("reset_busy", {31'd0, Busy}, 32'd1);
      chk("reset_rd1", RD1, 32'd0);
      chk("reset_rd2", RD2, 32'd0);

      // initial clear length and contents
      reset_and_count(busy_n);
      chk("clear_len", busy_n, 32'd32);
      chk("ready_busy", {31'd0, Busy}, 32'd0);
      for (int a = 0; a < 32; a++) begin
         RR1 = 5'(a); RR2 = 5'(31 - a);
         #1;
         chk("clear_rd1", RD1, 32'd0);
         chk("clear_rd2", RD2, 32'd0);
      end

      // write / overwrite top entry
      wr(5'd31, 32'hFFFF_FFFF);
      RR1 = 5'd31; RR2 = 5'd1;
      #1;
      chk("w31_rd1", RD1, 32'hFFFF_FFFF);
      chk("w31_rd2", RD2, 32'd0);
      wr(5'd31, 32'd23);
      chk("ow31_rd1", RD1, 32'd23);

      // hard-wired zero, including same-cycle collision
      RR1 = 5'd0;
      RegWrite = 1'b1; WriteReg = 5'd0; WriteData = 32'h1234_5678;
      #1;
      chk("zero_coll", RD1, 32'd0);
      tick();
      RegWrite = 1'b0;
      #1;
      chk("zero_after", RD1, 32'd0);

      // collision on entry 17, port 2; port 1 unaffected
      RR1 = 5'd31; RR2 = 5'd17;
      RegWrite = 1'b1; WriteReg = 5'd17; WriteData = 32'd47;
      #1;
      chk("coll17_rd2", RD2, COLL17);
      chk("coll17_rd1", RD1, 32'd23);
      tick();
      RegWrite = 1'b0;
      #1;
      chk("after17_rd2", RD2, 32'd47);

      // writes ignored while Busy; reads forced to zero during clear
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      RegWrite = 1'b1; WriteReg = 5'd11; WriteData = 32'd5;
      RR1 = 5'd31; RR2 = 5'd17;
      #1;
      chk("busy_rd1", RD1, 32'd0);
      chk("busy_rd2", RD2, 32'd0);
      busy_n = 0;
      while (Busy === 1'b1 && busy_n < 100) begin
         busy_n++;
         tick();
      end
      RegWrite = 1'b0;
      chk("clear2_len", busy_n, 32'd32);
      RR1 = 5'd11;
      #1;
      chk("busy_wr11", RD1, 32'd0);
      chk("cleared17", RD2, 32'd0);

      // reset partway through clear restarts the full sequence
      wr(5'd31, 32'd23);
      RR1 = 5'd31;
      #1;
      chk("pre_31", RD1, 32'd23);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) tick();
      chk("mid_busy", {31'd0, Busy}, 32'd1);
      reset_and_count(busy_n);
      chk("restart_len", busy_n, 32'd32);
      #1;
      chk("restart_31", RD1, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/br_param.md
BR_PARAM -- requirements
Module: br_param

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register width in bits.
REQ-002 SHALL have parameter ADDR_W, default 5, address width; depth DEPTH = 2**ADDR_W.
REQ-003 SHALL have parameter ZERO_REG, default 1; 1 = register 0 hard-wired to zero.
REQ-004 SHALL have port clk, input, 1, single clock; all state changes on rising edge.
REQ-005 SHALL have port rst_n, input, 1, synchronous active-low reset.
REQ-006 SHALL have port RR1, input, ADDR_W, read address port 1.
REQ-007 SHALL have port RR2, input, ADDR_W, read address port 2.
REQ-008 SHALL have port WriteReg, input, ADDR_W, write address.
REQ-009 SHALL have port WriteData, input, DATA_W, write data.
REQ-010 SHALL have port RegWrite, input, 1, write enable.
REQ-011 SHALL have port RD1, output, DATA_W, read data port 1.
REQ-012 SHALL have port RD2, output, DATA_W, read data port 2.
REQ-013 SHALL have port Busy, output, 1, high while the bank is being cleared.

Function
REQ-014 SHALL implement a two-state FSM: CLEAR, READY; Busy = (state == CLEAR), registered.
REQ-015 SHALL, in CLEAR with rst_n high, write 0 to entry cnt each cycle and increment cnt.
REQ-016 SHALL move CLEAR -> READY on the edge that clears entry DEPTH-1; Busy high for exactly DEPTH cycles after rst_n release.
REQ-017 SHALL stay in READY until rst_n is sampled low; no other transition exists.
REQ-018 SHALL, in READY, write WriteData to entry WriteReg on the rising edge when RegWrite = 1; one-cycle write latency.
REQ-019 SHALL ignore RegWrite entirely while Busy = 1; no entry modified except by the clear sequence.
REQ-020 SHALL provide combinational reads: RD1 = entry[RR1], RD2 = entry[RR2], zero latency, both ports independent, same address allowed on both.
REQ-021 SHALL drive RD1 and RD2 to 0 while Busy = 1, regardless of addresses.
REQ-022 SHALL, when ZERO_REG = 1, discard writes to address 0 and return 0 for reads of address 0 in all states.
REQ-023 SHALL, when ZERO_REG = 0, treat address 0 as an ordinary entry.
REQ-024 SHALL size cnt to ADDR_W bits; wrap from DEPTH-1 to 0 coincides with the CLEAR -> READY transition.

Reset
REQ-025 SHALL, on any rising edge with rst_n = 0, set state = CLEAR, cnt = 0, Busy = 1; RD1 = RD2 = 0 follows from REQ-021.
REQ-026 SHALL treat rst_n low mid-clear or mid-operation identically: clear sequence restarts from entry 0, full DEPTH cycles.
REQ-027 SHALL leave entry contents untouched while rst_n is held low; clearing occurs only after release.

Configuration
REQ-028 SHALL support macro BR_BYPASS_EN.
REQ-029 SHALL, with BR_BYPASS_EN defined, in READY with RegWrite = 1 and RRx == WriteReg, drive RDx = WriteData combinationally (write-first); excluded for address 0 when ZERO_REG = 1.
REQ-030 SHALL, without BR_BYPASS_EN, return the pre-write entry value on a same-cycle read/write collision (read-first).

Verification
REQ-031 SHALL cover: rst_n low 1 cycle then high -> Busy high exactly 32 cycles (defaults), then RD1/RD2 = 0 for addresses 0..31.
REQ-032 SHALL cover: READY, write 32'hFFFFFFFF to 31, next cycle RR1 = 31, RR2 = 1 -> RD1 = 32'hFFFFFFFF, RD2 = 0; overwrite 31 with 23 -> RD1 = 23.
REQ-033 SHALL cover: ZERO_REG = 1, write 32'h12345678 to 0 -> RD1 = 0 with RR1 = 0, including same-cycle collision with bypass enabled.
REQ-034 SHALL cover: same cycle RegWrite = 1, WriteReg = 17, WriteData = 47, RR2 = 17, prior value 0 -> RD2 = 47 with BR_BYPASS_EN, RD2 = 0 without; RD2 = 47 next cycle in both builds.
REQ-035 SHALL cover: RegWrite = 1 to address 11 with data 5 during Busy -> after READY, RR1 = 11 reads 0.
REQ-036 SHALL cover: rst_n low at clear cycle 10, entry 31 previously 23 -> Busy re-asserted, 32 further Busy cycles after release, entry 31 reads 0.
